adc_spi_capture: RTL
====================

// Module: adc_spi_capture
// PURPOSE
//   Serial front end for a 12-bit SPI ADC (AD7476-style frame). Runs a timed conversion per
//   sample period and drives CS_N and SCLK. Deserialises SDATA and presents a parallel 12-bit
//   sample plus a one-cycle strobe, ready for the downstream sample filter stage.
// PARAMETERS
//   CLK_DIV        4    clk cycles per SCLK half-period (>=2)
//   FRAME_BITS     16   SCLK rising edges per frame; last 12 bits are data, MSB first
//   CS_SETUP       2    clk cycles from CS_N fall to first SCLK fall
//   SAMPLE_PERIOD  200  clk cycles between frame starts
//                       (>= CS_SETUP + 2*CLK_DIV*FRAME_BITS + 2)
// PORTS
//   clk           in   1   system clock; all logic on posedge
//   rst           in   1   asynchronous reset, active-high
//   en            in   1   1 = start frames on sample ticks
//   adc_sdata     in   1   ADC serial data; changes after SCLK fall
//   adc_cs_n      out  1   ADC chip select, active-low
//   adc_sclk      out  1   serial clock, idles high
//   sample        out  12  last captured sample, unsigned
//   sample_valid  out  1   one-clk strobe: sample updated this cycle
//   overrun       out  1   sticky: a sample tick arrived while a frame was in progress
// BEHAVIOUR
//   Reset values: adc_cs_n=1, adc_sclk=1, sample=0, sample_valid=0, overrun=0.
//     Also on reset: state IDLE, all counters 0.
//   Rate counter
//     - Free-running 0..SAMPLE_PERIOD-1; tick when it reaches SAMPLE_PERIOD-1.
//     - Held at 0 while en=0.
//   FSM: IDLE -> SETUP -> SHIFT -> DONE -> IDLE
//     IDLE : on tick with en=1: adc_cs_n<=0, go to SETUP.
//     SETUP: wait CS_SETUP cycles; then adc_sclk<=0 (first fall), go to SHIFT.
//     SHIFT: divider toggles adc_sclk every CLK_DIV cycles.
//       - On each clk cycle where adc_sclk is driven 0->1, shift adc_sdata in:
//         shreg <= {shreg[FRAME_BITS-2:0], adc_sdata}; bit counter +1.
//       - After the FRAME_BITS-th rising edge, SCLK stays high; go to DONE.
//     DONE (1 cycle): adc_cs_n<=1, sample<=shreg[11:0], sample_valid<=1; go to IDLE.
//   Latency: sample_valid and the sample update occur 1 clk after the final SCLK rise.
//     Frame length = CS_SETUP + 2*CLK_DIV*FRAME_BITS (approx.) + 1 clk.
//   Boundary conditions
//     - tick while state!=IDLE: tick ignored, overrun<=1 (sticky until rst or en=0).
//     - en falls mid-frame: current frame completes and is delivered; no new frame starts.
//       overrun clears.
//     - en rises: first frame starts on the first tick, SAMPLE_PERIOD cycles later.
//     - rst mid-frame: immediate abort to reset values; partial data discarded, no strobe.
//     - sample holds its value between strobes; sample_valid is never high 2 cycles running.
// CONFIGURATION
//   ADC_LEADZERO_CHECK_EN
//     defined  : add output frame_err (1 bit, reset 0). In DONE, frame_err<=1 if
//                shreg[FRAME_BITS-1:12] != 0, else 0. Updated only with sample_valid.
//                sample is still updated.
//     undefined: no frame_err port; leading bits are ignored.
// TESTING
//   1 ADC model returns 0x0ABC (16b): 1 frame -> sample=12'hABC, sample_valid for exactly
//     1 clk, adc_cs_n high again.
//   2 Default params: 16 SCLK rises per frame, SCLK period 8 clk, first SCLK fall 2 clk
//     after CS_N fall. Frame starts exactly 200 clk apart.
//   3 Assert rst at SCLK edge 7 of a frame -> outputs at reset values in the same cycle.
//     No strobe. Next frame after release is correct (0x0555 -> 12'h555).
//   4 SAMPLE_PERIOD=100 (< frame length 132) -> overrun=1 after the 2nd tick.
//     Drop en -> overrun=0 and the in-flight sample is still delivered.
//   5 en=0 -> adc_cs_n stays 1 and adc_sclk stays 1 for 1000 clk, no strobes.
//   6 ADC_LEADZERO_CHECK_EN, ADC returns 0x8123 -> sample=12'h123, frame_err=1.
//     Then 0x0123 -> frame_err=0.

Source files
------------

// File: rtl/adc_spi_capture_if.sv
// adc_spi_capture_if: bundle between the ADC capture block and its surroundings.
// master = capture block (drives SPI pins and the sample bus); slave = the environment
// (drives en and the ADC serial data). Define ADC_LEADZERO_CHECK_EN to add frame_err.
interface adc_spi_capture_if;
    logic        en;
    logic        adc_sdata;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic [11:0] sample;
    logic        sample_valid;
    logic        overrun;
`ifdef ADC_LEADZERO_CHECK_EN
    logic        frame_err;
`endif

    modport master (
        input  en,
        input  adc_sdata,
        output adc_cs_n,
        output adc_sclk,
        output sample,
        output sample_valid,
`ifdef ADC_LEADZERO_CHECK_EN
        output frame_err,
`endif
        output overrun
    );

    modport slave (
        output en,
        output adc_sdata,
        input  adc_cs_n,
        input  adc_sclk,
        input  sample,
        input  sample_valid,
`ifdef ADC_LEADZERO_CHECK_EN
        input  frame_err,
`endif
        input  overrun
    );
endinterface

// File: rtl/adc_spi_capture.sv
// adc_spi_capture: timed SPI frame capture for a 12-bit AD7476-style ADC, one frame per sample period.
// Latency: sample and sample_valid update 1 clk after the final SCLK rise of a frame.
// Backpressure: none; sample_valid is a strobe, a sample tick landing mid-frame sets sticky overrun.
// Ports: clk, rst (async, active-high) plain; adc_if (master modport) carries en, adc_sdata in and
//        adc_cs_n, adc_sclk (idle high), sample[11:0], sample_valid, overrun out.
// Build option: define ADC_LEADZERO_CHECK_EN to add frame_err (leading frame bits not all zero).
module adc_spi_capture #(
    parameter int CLK_DIV       = 4,
    parameter int FRAME_BITS    = 16,
    parameter int CS_SETUP      = 2,
    parameter int SAMPLE_PERIOD = 200
) (
    input  logic                     clk,
    input  logic                     rst,
    adc_spi_capture_if.master        adc_if
);
    localparam int RW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int SW = $clog2(CS_SETUP + 1);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(FRAME_BITS + 1);

    localparam logic [RW-1:0] RATE_LAST  = RW'(SAMPLE_PERIOD - 1);
    localparam logic [SW-1:0] SETUP_LAST = SW'(CS_SETUP - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

    // Without the leading-zero check only the 12 data bits matter, so the
    // leading frame bits are simply shifted out of a 12-bit register.
`ifdef ADC_LEADZERO_CHECK_EN
    localparam int SHW = FRAME_BITS;
`else
    localparam int SHW = 12;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t          state_q;
    logic [RW-1:0]   rate_cnt_q, rate_cnt_d;
    logic [SW-1:0]   setup_cnt_q;
    logic [DW-1:0]   div_cnt_q;
    logic [BW-1:0]   bit_cnt_q;
    logic [SHW-1:0]  shreg_q;
    logic [11:0]     sample_q;
    logic            cs_n_q;
    logic            sclk_q;
    logic            valid_q;
    logic            overrun_q;
    logic            tick;
`ifdef ADC_LEADZERO_CHECK_EN
    logic            frame_err_q;
`endif

    // Sample-rate counter: parked at 0 while disabled so the first frame
    // after enable starts a full period later.
    always_comb begin
        rate_cnt_d = rate_cnt_q;
        if (!adc_if.en) begin
            rate_cnt_d = '0;
        end else if (rate_cnt_q == RATE_LAST) begin
            rate_cnt_d = '0;
        end else begin
            rate_cnt_d = rate_cnt_q + RW'(1);
        end
    end

    assign tick = adc_if.en && (rate_cnt_q == RATE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_cnt_q <= '0;
        end else begin
            rate_cnt_q <= rate_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            setup_cnt_q <= '0;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            sample_q    <= '0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef ADC_LEADZERO_CHECK_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;

            // Sticky overrun; dropping en is the only way to clear it short of reset.
            if (!adc_if.en) begin
                overrun_q <= 1'b0;
            end else if (tick && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        cs_n_q      <= 1'b0;
                        setup_cnt_q <= '0;
                        state_q     <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (setup_cnt_q == SETUP_LAST) begin
                        sclk_q    <= 1'b0;
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= ST_SHIFT;
                    end else begin
                        setup_cnt_q <= setup_cnt_q + SW'(1);
                    end
                end

                ST_SHIFT: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q <= '0;
                        if (!sclk_q) begin
                            // Rising edge: the ADC set the bit up after the previous fall.
                            sclk_q    <= 1'b1;
                            shreg_q   <= {shreg_q[SHW-2:0], adc_if.adc_sdata};
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            if (bit_cnt_q == BIT_LAST) begin
                                state_q <= ST_DONE;
                            end
                        end else begin
                            sclk_q <= 1'b0;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DW'(1);
                    end
                end

                ST_DONE: begin
                    cs_n_q   <= 1'b1;
                    sample_q <= shreg_q[11:0];
                    valid_q  <= 1'b1;
`ifdef ADC_LEADZERO_CHECK_EN
                    frame_err_q <= |shreg_q[SHW-1:12];
`endif
                    state_q  <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign adc_if.adc_cs_n     = cs_n_q;
    assign adc_if.adc_sclk     = sclk_q;
    assign adc_if.sample       = sample_q;
    assign adc_if.sample_valid = valid_q;
    assign adc_if.overrun      = overrun_q;
`ifdef ADC_LEADZERO_CHECK_EN
    assign adc_if.frame_err    = frame_err_q;
`endif

endmodule
